// File: rtl/karatsuba_seq32_mul.sv
// Sequential 2N x 2N unsigned multiplier. One combinational N x N Karatsuba core is time-shared
// over four cycles; the half-products are shifted and accumulated into a 4N-bit result.
module karatsuba_seq32_mul #(
  parameter int unsigned N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   a,
  input  logic [2*N-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*N-1:0]   out_p
);

  localparam int unsigned H = N / 2;
  localparam int unsigned W = 2 * N;
  localparam int unsigned P = 4 * N;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [P-1:0]   acc_q, acc_d;
  logic [P-1:0]   res_q, res_d;
  logic [W-1:0]   ra_q, ra_d;
  logic [W-1:0]   rb_q, rb_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  // Core operand select: cnt[1] picks the high half of a, cnt[0] the high half of b.
  logic [N-1:0]   core_a, core_b;
  logic [W-1:0]   core_s;

  always_comb begin
    core_a = cnt_q[1] ? ra_q[W-1:N] : ra_q[N-1:0];
    core_b = cnt_q[0] ? rb_q[W-1:N] : rb_q[N-1:0];
  end

  // Combinational Karatsuba core: three H x H style products instead of four.
  logic [H-1:0]   xl, xh, yl, yh;
  logic [H:0]     xs, ys;
  logic [W-1:0]   z0, z1, z2, zm;

  always_comb begin
    xl     = core_a[H-1:0];
    xh     = core_a[N-1:H];
    yl     = core_b[H-1:0];
    yh     = core_b[N-1:H];
    xs     = {1'b0, xl} + {1'b0, xh};
    ys     = {1'b0, yl} + {1'b0, yh};
    z0     = W'(xl) * W'(yl);
    z2     = W'(xh) * W'(yh);
    zm     = W'(xs) * W'(ys);
    z1     = zm - z0 - z2;
    core_s = (z2 << N) + (z1 << H) + z0;
  end

  // Weight of the current half-product: 0, N, N, 2N for cnt 0..3.
  logic [P-1:0]   term;

  always_comb begin
    term = P'(core_s);
    unique case (cnt_q)
      2'd0:       term = P'(core_s);
      2'd1, 2'd2: term = P'(core_s) << N;
      2'd3:       term = P'(core_s) << (2 * N);
      default:    term = P'(core_s);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          ra_d       = a;
          rb_d       = b;
          acc_d      = '0;
          cnt_d      = 2'd0;
          in_ready_d = 1'b0;
          state_d    = StMul;
        end
      end
      StMul: begin
        acc_d = acc_q + term;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // Result register keeps out_p stable outside DONE while acc is reused.
          res_d       = acc_q + term;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      acc_q       <= '0;
      res_q       <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = res_q;

endmodule

// File: tb/tb_karatsuba_seq32_mul.sv
// Directed and randomised self-checking bench for karatsuba_seq32_mul.
module tb_karatsuba_seq32_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;

  int n_checks = 0;
  int n_fail   = 0;

  karatsuba_seq32_mul #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold = cycles out_ready stays low in DONE.
  task automatic do_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [63:0] exp, input int hold, input bit chk_lat);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = ~xa;
    b        = xb ^ 32'h5A5A_A5A5;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_out_p"}, out_p, exp);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (chk_lat) check({tag, "_release_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          stable;
    bit          pulsed;
    int          rise [$];
    logic        prev_v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_p", out_p, 64'h0);
    rst = 1'b0;
    tick();

    // Maximum operands and cross terms
    do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b1);
    do_op("hi_hi", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0, 1'b1);
    do_op("cross", 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 0, 1'b1);
    check("hold_last_out_p", out_p, 64'h0000_0003_000A_0008);

    // Backpressure in DONE with a competing in_valid
    a        = 32'h0000_FFFF;
    b        = 32'h0000_FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_out_p", out_p, 64'h0000_0000_FFFE_0001);
    a        = 32'h0000_0007;
    b        = 32'h0000_0009;
    in_valid = 1'b1;
    stable   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || in_ready || out_p !== 64'h0000_0000_FFFE_0001) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_idle", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_no_new_accept", out_p, 64'h0000_0000_FFFE_0001);

    // Reset in the middle of MUL
    a        = 32'h1234_5678;
    b        = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_p", out_p, 64'h0);
    pulsed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) pulsed = 1'b1;
    end
    check("abort_no_pulse", 64'(pulsed), 64'd0);
    do_op("after_abort", 32'd3, 32'd5, 64'd15, 0, 1'b1);

    // Throughput with both handshakes tied high
    a         = 32'hDEAD_BEEF;
    b         = 32'h0000_0002;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_v    = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid && !prev_v) rise.push_back(c);
      prev_v = out_valid;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("tput_count", 64'(rise.size()), 64'd5);
    if (rise.size() >= 3) begin
      check("tput_gap0", 64'(rise[1] - rise[0]), 64'd6);
      check("tput_gap1", 64'(rise[2] - rise[1]), 64'd6);
    end
    check("tput_out_p", out_p, 64'h0000_0001_BD5B_7DDE);

    // Random operands with random gaps on both sides
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i % 7 == 0) ra = 32'hFFFF_FFFF;
      repeat ($urandom_range(0, 2)) tick();
      do_op("rand", ra, rb, 64'(ra) * 64'(rb), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
